// File: rtl/ltc4284_bc_pkg.sv
// Shared types and constants for the LTC4284 broadcast-receiver poller.
// Holds the state encoding, status bit indices, transfer sizes and helpers.
package ltc4284_bc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SETUP,
        S_SCK_LO,
        S_SCK_HI,
        S_HOLD
    } state_t;

    localparam int ST_PRESENT = 0;
    localparam int ST_SPD0    = 1;
    localparam int ST_SPD1    = 2;
    localparam int ST_SPD_ERR = 3;
    localparam int ST_FRAME   = 4;
    localparam int ST_SHORT   = 5;
    localparam int ST_LONG    = 6;
    localparam int ST_PEC     = 7;

    localparam int XFER_BITS = 168;
    localparam int STAT_BITS = 8;
    localparam int DATA_BITS = XFER_BITS - STAT_BITS;

    localparam logic [7:0] LAST_BIT  = 8'(XFER_BITS - 1);
    localparam logic [7:0] PROBE_BIT = 8'(STAT_BITS - 1);

    // Present and none of the error flags [7:3] raised.
    function automatic logic status_ok(input logic [7:0] s);
        return s[ST_PRESENT] && (s[ST_PEC:ST_SPD_ERR] == 5'b0);
    endfunction

    // Present with at least one error flag raised.
    function automatic logic status_err(input logic [7:0] s);
        return s[ST_PRESENT] && (s[ST_PEC:ST_SPD_ERR] != 5'b0);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ltc4284_spi_rd_eng.sv
// SPI mode-0 read engine: generates sck, shifts miso LSB-first, counts bits.
// Ports: clk_24m/rst, start/abort/clr control, exit_chk enables the early
// no-packet exit, miso_s data in; sck, done pulse, full flag, shift register.
module ltc4284_spi_rd_eng
    import ltc4284_bc_pkg::*;
#(
    parameter int SCK_HALF = 4
)(
    input  logic                 clk_24m,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 clr,
    input  logic                 exit_chk,
    input  logic                 miso_s,
    output logic                 sck,
    output logic                 done,
    output logic                 full,
    output logic [XFER_BITS-1:0] shift
);

    localparam logic [15:0] HALF_END = 16'(SCK_HALF - 1);

    state_t      state;
    logic [15:0] hcnt;
    logic [7:0]  bcnt;
    logic        last_bit;

    // Stop after the final bit, or after the status byte when the
    // receiver reports no packet present.
    always_comb begin
        last_bit = (bcnt == LAST_BIT) ||
                   (exit_chk && bcnt == PROBE_BIT && !shift[ST_PRESENT]);
    end

    always_ff @(posedge clk_24m) begin
        if (rst) begin
            state <= S_IDLE;
            hcnt  <= '0;
            bcnt  <= '0;
            sck   <= 1'b0;
            done  <= 1'b0;
            full  <= 1'b0;
            shift <= '0;
        end else begin
            done <= 1'b0;
            if (clr) begin
                shift <= '0;
            end
            if (abort) begin
                state <= S_IDLE;
                hcnt  <= '0;
                bcnt  <= '0;
                sck   <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start) begin
                            state <= S_SCK_LO;
                            hcnt  <= '0;
                            bcnt  <= '0;
                            full  <= 1'b0;
                        end
                    end
                    S_SCK_LO: begin
                        if (hcnt == HALF_END) begin
                            hcnt        <= '0;
                            shift[bcnt] <= miso_s;
                            sck         <= 1'b1;
                            state       <= S_SCK_HI;
                        end else begin
                            hcnt <= hcnt + 16'd1;
                        end
                    end
                    S_SCK_HI: begin
                        if (hcnt == HALF_END) begin
                            hcnt <= '0;
                            sck  <= 1'b0;
                            if (last_bit) begin
                                state <= S_IDLE;
                                done  <= 1'b1;
                                full  <= (bcnt == LAST_BIT);
                            end else begin
                                bcnt  <= bcnt + 8'd1;
                                state <= S_SCK_LO;
                            end
                        end else begin
                            hcnt <= hcnt + 16'd1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        sck   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/ltc4284_bc_poll.sv
// Periodic poller for the LTC4284 broadcast receiver over a read-only SPI.
// Ports: clk_24m, rst, run in; bc_enb, cs_n, sck, busy out; miso in;
// pkt_valid/pkt_status/pkt_data/pkt_ok packet outputs; good_cnt/err_cnt.
module ltc4284_bc_poll
    import ltc4284_bc_pkg::*;
#(
    parameter int POLL_CYC = 2400,
    parameter int SCK_HALF = 4,
    parameter int CS_SETUP = 4
)(
    input  logic                 clk_24m,
    input  logic                 rst,
    input  logic                 run,
    output logic                 bc_enb,
    output logic                 cs_n,
    output logic                 sck,
    input  logic                 miso,
    output logic                 busy,
    output logic                 pkt_valid,
    output logic [7:0]           pkt_status,
    output logic [DATA_BITS-1:0] pkt_data,
    output logic                 pkt_ok,
    output logic [15:0]          good_cnt,
    output logic [15:0]          err_cnt
);

    localparam logic [15:0] POLL_END  = 16'(POLL_CYC - 1);
    localparam logic [15:0] SETUP_END = 16'(CS_SETUP - 1);

    state_t               state;
    logic [15:0]          cnt;
    logic                 miso_s;
    logic                 eng_start;
    logic                 eng_clr;
    logic                 eng_done;
    logic                 eng_full;
    logic [XFER_BITS-1:0] eng_shift;

    // Engine start and shift clear coincide with the transitions into
    // SCK_LO and SETUP so no extra cycle is added to either phase.
    always_comb begin
        eng_start = run && (state == S_SETUP) && (cnt == SETUP_END);
        eng_clr   = run && (state == S_WAIT) && (cnt == POLL_END);
    end

    ltc4284_spi_rd_eng #(
        .SCK_HALF (SCK_HALF)
    ) u_eng (
        .clk_24m  (clk_24m),
        .rst      (rst),
        .start    (eng_start),
        .abort    (!run),
        .clr      (eng_clr),
        .exit_chk (1'b1),
        .miso_s   (miso_s),
        .sck      (sck),
        .done     (eng_done),
        .full     (eng_full),
        .shift    (eng_shift)
    );

    always_ff @(posedge clk_24m) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            miso_s     <= 1'b0;
            bc_enb     <= 1'b0;
            cs_n       <= 1'b1;
            busy       <= 1'b0;
            pkt_valid  <= 1'b0;
            pkt_status <= '0;
            pkt_data   <= '0;
            pkt_ok     <= 1'b0;
            good_cnt   <= '0;
            err_cnt    <= '0;
        end else begin
            miso_s    <= miso;
            bc_enb    <= run;
            pkt_valid <= 1'b0;
            if (!run && state != S_IDLE) begin
                state <= S_IDLE;
                cnt   <= '0;
                cs_n  <= 1'b1;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (run) begin
                            state <= S_WAIT;
                            cnt   <= '0;
                        end
                    end
                    S_WAIT: begin
                        if (cnt == POLL_END) begin
                            state <= S_SETUP;
                            cnt   <= '0;
                            cs_n  <= 1'b0;
                            busy  <= 1'b1;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    S_SETUP: begin
                        if (cnt == SETUP_END) begin
                            state <= S_SCK_LO;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    // The engine owns the sck phases; this state covers
                    // the whole clocked transfer until it reports done.
                    S_SCK_LO, S_SCK_HI: begin
                        if (eng_done) begin
                            state <= S_HOLD;
                            cnt   <= '0;
                            cs_n  <= 1'b1;
                            busy  <= 1'b0;
                            if (eng_full && eng_shift[ST_PRESENT]) begin
                                pkt_valid  <= 1'b1;
                                pkt_status <= eng_shift[STAT_BITS-1:0];
                                pkt_data   <= eng_shift[XFER_BITS-1:STAT_BITS];
                                pkt_ok     <= status_ok(eng_shift[7:0]);
                                if (status_ok(eng_shift[7:0])) begin
                                    good_cnt <= sat_inc(good_cnt);
                                end
                                if (status_err(eng_shift[7:0])) begin
                                    err_cnt <= sat_inc(err_cnt);
                                end
                            end
                        end
                    end
                    S_HOLD: begin
                        if (cnt == SETUP_END) begin
                            state <= S_WAIT;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        cs_n  <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ltc4284_bc_poll.sv
// Testbench for ltc4284_bc_poll: behavioural SPI receiver plus a packet
// level reference model, directed scenarios and randomized packets.
module tb_ltc4284_bc_poll;

    localparam int POLL = 60;
    localparam int HALF = 2;
    localparam int CSS  = 3;

    logic         clk_24m = 1'b0;
    logic         rst     = 1'b1;
    logic         run     = 1'b0;
    logic         miso    = 1'b0;
    logic         bc_enb;
    logic         cs_n;
    logic         sck;
    logic         busy;
    logic         pkt_valid;
    logic [7:0]   pkt_status;
    logic [159:0] pkt_data;
    logic         pkt_ok;
    logic [15:0]  good_cnt;
    logic [15:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    ltc4284_bc_poll #(
        .POLL_CYC (POLL),
        .SCK_HALF (HALF),
        .CS_SETUP (CSS)
    ) dut (
        .clk_24m    (clk_24m),
        .rst        (rst),
        .run        (run),
        .bc_enb     (bc_enb),
        .cs_n       (cs_n),
        .sck        (sck),
        .miso       (miso),
        .busy       (busy),
        .pkt_valid  (pkt_valid),
        .pkt_status (pkt_status),
        .pkt_data   (pkt_data),
        .pkt_ok     (pkt_ok),
        .good_cnt   (good_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk_24m = ~clk_24m;

    // Receiver: frame latched at cs_n fall, bit 0 presented first,
    // next bit driven after each sck fall (mode 0).
    logic [167:0] rx_frame = '0;
    logic [167:0] cur      = '0;
    int           idx      = 0;
    int           rises    = 0;

    always @(negedge cs_n) begin
        cur   = rx_frame;
        idx   = 0;
        rises = 0;
        miso  = cur[0];
    end

    always @(negedge sck) begin
        if (cs_n === 1'b0) begin
            idx = idx + 1;
            if (idx < 168) miso = cur[idx];
        end
    end

    always @(posedge sck) rises = rises + 1;

    // Packet capture, sampled away from the active edge.
    int           pv_cnt = 0;
    logic [7:0]   cap_st;
    logic [159:0] cap_data;
    logic         cap_ok;
    logic [15:0]  cap_good;
    logic [15:0]  cap_err;

    always @(negedge clk_24m) begin
        if (pkt_valid === 1'b1) begin
            pv_cnt   = pv_cnt + 1;
            cap_st   = pkt_status;
            cap_data = pkt_data;
            cap_ok   = pkt_ok;
            cap_good = good_cnt;
            cap_err  = err_cnt;
        end
    end

    // Reference model state.
    int           m_good = 0;
    int           m_err  = 0;
    logic [7:0]   m_st   = '0;
    logic [159:0] m_data = '0;

    localparam logic [159:0] DATA0 =
        160'h0123456789ABCDEF0123456789ABCDEF89ABCDEF;

    task automatic chk(input string tag, input logic [159:0] obs,
                       input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cs(input logic lvl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_24m);
            if (cs_n === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rises(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_24m);
            if (cs_n === 1'b0 && rises >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_packet(input string tag, input logic [7:0] st,
                             input logic [159:0] d);
        bit ok;
        int pv0;
        bit present;
        bit good;
        bit bad;
        rx_frame = {d, st};
        pv0 = pv_cnt;
        wait_cs(1'b0, ok);
        chk({tag, "_cs_fall"}, ok, 1);
        chk({tag, "_busy_hi"}, busy, 1);
        wait_cs(1'b1, ok);
        chk({tag, "_cs_rise"}, ok, 1);
        @(negedge clk_24m);
        present = st[0];
        good    = present && (st[7:3] == 5'd0);
        bad     = present && (st[7:3] != 5'd0);
        if (good) m_good = (m_good + 1 > 65535) ? 65535 : m_good + 1;
        if (bad)  m_err  = (m_err + 1 > 65535) ? 65535 : m_err + 1;
        if (present) begin
            m_st   = st;
            m_data = d;
            chk({tag, "_rises"}, rises, 168);
            chk({tag, "_pv_cnt"}, pv_cnt - pv0, 1);
            chk({tag, "_status"}, cap_st, st);
            chk({tag, "_data"}, cap_data, d);
            chk({tag, "_ok"}, cap_ok, good);
            chk({tag, "_good"}, cap_good, m_good);
            chk({tag, "_err"}, cap_err, m_err);
        end else begin
            chk({tag, "_rises"}, rises, 8);
            chk({tag, "_pv_cnt"}, pv_cnt - pv0, 0);
            chk({tag, "_status"}, pkt_status, m_st);
            chk({tag, "_data"}, pkt_data, m_data);
        end
        chk({tag, "_busy_lo"}, busy, 0);
        chk({tag, "_good_now"}, good_cnt, m_good);
        chk({tag, "_err_now"}, err_cnt, m_err);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cs_n"}, cs_n, 1);
        chk({tag, "_sck"}, sck, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_bc_enb"}, bc_enb, 0);
        chk({tag, "_pv"}, pkt_valid, 0);
        chk({tag, "_status"}, pkt_status, 0);
        chk({tag, "_data"}, pkt_data, 0);
        chk({tag, "_ok"}, pkt_ok, 0);
        chk({tag, "_good"}, good_cnt, 0);
        chk({tag, "_err"}, err_cnt, 0);
    endtask

    initial begin
        bit           ok;
        int           pv0;
        logic [7:0]   st;
        logic [159:0] d;

        repeat (3) @(negedge clk_24m);
        chk_reset("reset");
        rst = 1'b0;
        @(negedge clk_24m);
        chk("idle_cs_n", cs_n, 1);

        run = 1'b1;
        @(negedge clk_24m);
        chk("bc_enb_on", bc_enb, 1);
        do_packet("good0", 8'h01, DATA0);

        d = {$urandom, $urandom, $urandom, $urandom, $urandom};
        do_packet("nopkt", 8'h00, d);

        d = {$urandom, $urandom, $urandom, $urandom, $urandom};
        do_packet("pec", 8'h81, d);

        // Abort part-way through a transfer.
        d = {$urandom, $urandom, $urandom, $urandom, $urandom};
        rx_frame = {d, 8'h01};
        pv0 = pv_cnt;
        wait_rises(50, ok);
        chk("abort_reach50", ok, 1);
        run = 1'b0;
        @(negedge clk_24m);
        chk("abort_cs_n", cs_n, 1);
        chk("abort_sck", sck, 0);
        chk("abort_busy", busy, 0);
        chk("abort_bc_enb", bc_enb, 0);
        repeat (2 * POLL) @(negedge clk_24m);
        chk("abort_stay_idle", cs_n, 1);
        chk("abort_no_pv", pv_cnt - pv0, 0);
        chk("abort_good", good_cnt, m_good);
        run = 1'b1;
        do_packet("after_abort", 8'h05, d);

        // Reset in the middle of a transfer.
        d = {$urandom, $urandom, $urandom, $urandom, $urandom};
        rx_frame = {d, 8'h01};
        pv0 = pv_cnt;
        wait_rises(100, ok);
        chk("rst_reach100", ok, 1);
        rst = 1'b1;
        @(negedge clk_24m);
        chk_reset("midrst");
        chk("midrst_no_pv", pv_cnt - pv0, 0);
        rst = 1'b0;
        m_good = 0;
        m_err  = 0;
        m_st   = '0;
        m_data = '0;
        do_packet("after_rst", 8'h03, d);

        for (int i = 0; i < 6; i++) begin
            st = 8'($urandom);
            if (i % 3 == 0) st[7:3] = 5'd0;
            st[0] = (i != 4);
            d = {$urandom, $urandom, $urandom, $urandom, $urandom};
            do_packet($sformatf("rand%0d", i), st, d);
        end

        // Saturation of the good counter.
        force dut.good_cnt = 16'hFFFE;
        @(negedge clk_24m);
        release dut.good_cnt;
        m_good = 65534;
        for (int i = 0; i < 3; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom, $urandom};
            do_packet($sformatf("sat%0d", i), 8'h01, d);
        end
        chk("sat_final", good_cnt, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
